control_sequencer: RTL and testbench

Hardwired control unit for the single-bus CPU datapath. Decodes the instruction held in IR and sequences the datapath through fetch (T0–T2) and execute (T3–T6) for register-register ALU, MUL/DIV, NOP and HALT instructions. It drives every register-enable, bus-source, ALU-opcode and memory-read strobe that the datapath exposes. It stalls on a memory-ready handshake during fetch.

---
 rtl/cpu_ctrl_pkg.sv | 62 ++++++
 rtl/decoder_4_to_16.sv | 17 +
 rtl/control_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_control_sequencer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg
// Shared definitions for the hardwired control unit: ALU opcodes, IR field
// positions, the sequencer state encoding and opcode classification helpers.
package cpu_ctrl_pkg;

  // ALU / instruction opcodes (IR[31:27])
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_NEG  = 5'b10000;
  localparam logic [4:0] OP_NOT  = 5'b10001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // IR field bit positions
  localparam int IR_OPC_MSB = 31;
  localparam int IR_OPC_LSB = 27;
  localparam int IR_RA_MSB  = 26;
  localparam int IR_RA_LSB  = 23;
  localparam int IR_RB_MSB  = 22;
  localparam int IR_RB_LSB  = 19;
  localparam int IR_RC_MSB  = 18;
  localparam int IR_RC_LSB  = 15;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_FETCH0 = 4'd1,
    ST_FETCH1 = 4'd2,
    ST_FETCH2 = 4'd3,
    ST_T3     = 4'd4,
    ST_T4     = 4'd5,
    ST_T5     = 4'd6,
    ST_T6     = 4'd7,
    ST_HALTED = 4'd8
  } state_e;

  // Opcodes that go through the Y/ALU/Z execute path (T3..T5/T6)
  function automatic logic is_exec_op(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL,
      OP_ROR, OP_ROL, OP_MUL, OP_DIV, OP_NEG, OP_NOT: is_exec_op = 1'b1;
      default:                                         is_exec_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_unary_op(input logic [4:0] op);
    is_unary_op = (op == OP_NEG) || (op == OP_NOT);
  endfunction

  function automatic logic is_muldiv_op(input logic [4:0] op);
    is_muldiv_op = (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/decoder_4_to_16.sv
// decoder_4_to_16
// Combinational 4-to-16 one-hot decoder with enable.
//   sel_i    : 4-bit index
//   en_i     : when low, output is all zeros
//   onehot_o : one-hot of sel_i when enabled
module decoder_4_to_16 (
  input  logic [3:0]  sel_i,
  input  logic        en_i,
  output logic [15:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[sel_i] = 1'b1;
  end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer
// Hardwired Moore control unit for a single-bus CPU datapath. Sequences fetch
// (FETCH0..FETCH2) and execute (T3..T6) for register-register ALU, MUL/DIV,
// NOP and HALT, stalling in FETCH1 until memory reports ready.
//   clk_i, clr_i      : clock, asynchronous active-high reset
//   ir_i              : current IR contents (decoded from T3 onward)
//   mem_ready_i       : MDatain valid, only looked at in FETCH1
//   stop_i            : pause request, only honoured in IDLE / at boundaries
//   *_out_o, r_out_o  : bus-source selects (at most one active per cycle)
//   *_in_o, r_in_o    : register load enables (r_in_o bit 0 never set)
//   inc_pc_o, read_o  : PC increment, MDR input mux select
//   operation_o       : ALU opcode, non-zero only in T4
//   run_o, illegal_o  : running status, undefined-opcode pulse in T3
//
// state     | meaning
// ----------+-------------------------------------------------
// IDLE      | paused, waiting for stop low
// FETCH0    | PC -> MAR, PC incremented
// FETCH1    | memory read into MDR, held until mem_ready
// FETCH2    | MDR -> IR
// T3        | decode; Rb -> Y for execute-class opcodes
// T4        | ALU operates, result into Z
// T5        | Zlow -> Ra (or LO for MUL/DIV)
// T6        | Zhigh -> HI (MUL/DIV only)
// HALTED    | stopped until clr
module control_sequencer
  import cpu_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        clr_i,
  input  logic [31:0] ir_i,
  input  logic        mem_ready_i,
  input  logic        stop_i,
  output logic        pc_out_o,
  output logic        mdr_out_o,
  output logic        zlow_out_o,
  output logic        zhigh_out_o,
  output logic        hi_out_o,
  output logic        lo_out_o,
  output logic [15:0] r_out_o,
  output logic [15:0] r_in_o,
  output logic        mar_in_o,
  output logic        pc_in_o,
  output logic        mdr_in_o,
  output logic        ir_in_o,
  output logic        y_in_o,
  output logic        zlow_in_o,
  output logic        zhigh_in_o,
  output logic        hi_in_o,
  output logic        lo_in_o,
  output logic        inc_pc_o,
  output logic        read_o,
  output logic [4:0]  operation_o,
  output logic        run_o,
  output logic        illegal_o
);

  state_e      state_q, state_d;
  logic [4:0]  opcode;
  logic [3:0]  ra, rb, rc;
  logic        ir_unused;

  logic        r_out_en;
  logic [3:0]  r_out_sel;
  logic        r_in_en;

  assign opcode = ir_i[IR_OPC_MSB:IR_OPC_LSB];
  assign ra     = ir_i[IR_RA_MSB:IR_RA_LSB];
  assign rb     = ir_i[IR_RB_MSB:IR_RB_LSB];
  assign rc     = ir_i[IR_RC_MSB:IR_RC_LSB];
  // Low IR bits carry immediates for instructions this unit does not sequence.
  assign ir_unused = ^ir_i[IR_RC_LSB-1:0];

  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   state_d = stop_i ? ST_IDLE : ST_FETCH0;
      ST_FETCH0: state_d = ST_FETCH1;
      ST_FETCH1: state_d = mem_ready_i ? ST_FETCH2 : ST_FETCH1;
      ST_FETCH2: state_d = ST_T3;
      ST_T3: begin
        if (is_exec_op(opcode))    state_d = ST_T4;
        else if (opcode == OP_HALT) state_d = ST_HALTED;
        else                        state_d = stop_i ? ST_IDLE : ST_FETCH0;
      end
      ST_T4:     state_d = ST_T5;
      ST_T5: begin
        if (is_muldiv_op(opcode)) state_d = ST_T6;
        else                      state_d = stop_i ? ST_IDLE : ST_FETCH0;
      end
      ST_T6:     state_d = stop_i ? ST_IDLE : ST_FETCH0;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pc_out_o    = 1'b0;
    mdr_out_o   = 1'b0;
    zlow_out_o  = 1'b0;
    zhigh_out_o = 1'b0;
    hi_out_o    = 1'b0;
    lo_out_o    = 1'b0;
    mar_in_o    = 1'b0;
    pc_in_o     = 1'b0;
    mdr_in_o    = 1'b0;
    ir_in_o     = 1'b0;
    y_in_o      = 1'b0;
    zlow_in_o   = 1'b0;
    zhigh_in_o  = 1'b0;
    hi_in_o     = 1'b0;
    lo_in_o     = 1'b0;
    inc_pc_o    = 1'b0;
    read_o      = 1'b0;
    operation_o = 5'd0;
    illegal_o   = 1'b0;
    r_out_en    = 1'b0;
    r_out_sel   = rb;
    r_in_en     = 1'b0;
    run_o       = (state_q != ST_IDLE) && (state_q != ST_HALTED);
    case (state_q)
      ST_FETCH0: begin
        pc_out_o = 1'b1;
        mar_in_o = 1'b1;
        inc_pc_o = 1'b1;
      end
      ST_FETCH1: begin
        read_o   = 1'b1;
        mdr_in_o = 1'b1;
      end
      ST_FETCH2: begin
        mdr_out_o = 1'b1;
        ir_in_o   = 1'b1;
      end
      ST_T3: begin
        if (is_exec_op(opcode)) begin
          r_out_en = 1'b1;
          y_in_o   = 1'b1;
        end else if (opcode != OP_NOP && opcode != OP_HALT) begin
          illegal_o = 1'b1;
        end
      end
      ST_T4: begin
        operation_o = opcode;
        r_out_en    = 1'b1;
        r_out_sel   = is_unary_op(opcode) ? rb : rc;
        zlow_in_o   = 1'b1;
        zhigh_in_o  = 1'b1;
      end
      ST_T5: begin
        zlow_out_o = 1'b1;
        if (is_muldiv_op(opcode)) lo_in_o = 1'b1;
        else                      r_in_en = (ra != 4'd0);  // R0 is read-only
      end
      ST_T6: begin
        zhigh_out_o = 1'b1;
        hi_in_o     = 1'b1;
      end
      default: ;
    endcase
  end

  decoder_4_to_16 u_dec_r_out (
    .sel_i    (r_out_sel),
    .en_i     (r_out_en),
    .onehot_o (r_out_o)
  );

  decoder_4_to_16 u_dec_r_in (
    .sel_i    (ra),
    .en_i     (r_in_en),
    .onehot_o (r_in_o)
  );

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  typedef struct packed {
    logic        pc_out, mdr_out, zlow_out, zhigh_out, hi_out, lo_out;
    logic [15:0] r_out, r_in;
    logic        mar_in, pc_in, mdr_in, ir_in, y_in, zlow_in, zhigh_in, hi_in, lo_in;
    logic        inc_pc, read;
    logic [4:0]  operation;
    logic        run, illegal;
  } out_t;

  localparam int P_IDLE = 0, P_F0 = 1, P_F1 = 2, P_F2 = 3, P_T3 = 4,
                 P_T4 = 5, P_T5 = 6, P_T6 = 7, P_HALT = 8;

  logic        clk, clr, mem_ready, stop;
  logic [31:0] ir;
  logic        pc_out, mdr_out, zlow_out, zhigh_out, hi_out, lo_out;
  logic [15:0] r_out, r_in;
  logic        mar_in, pc_in, mdr_in, ir_in, y_in, zlow_in, zhigh_in, hi_in, lo_in;
  logic        inc_pc, read, run, illegal;
  logic [4:0]  operation;
  out_t        obs;

  int n_assert = 0;
  int n_fail   = 0;

  control_sequencer dut (
    .clk_i(clk), .clr_i(clr), .ir_i(ir), .mem_ready_i(mem_ready), .stop_i(stop),
    .pc_out_o(pc_out), .mdr_out_o(mdr_out), .zlow_out_o(zlow_out),
    .zhigh_out_o(zhigh_out), .hi_out_o(hi_out), .lo_out_o(lo_out),
    .r_out_o(r_out), .r_in_o(r_in), .mar_in_o(mar_in), .pc_in_o(pc_in),
    .mdr_in_o(mdr_in), .ir_in_o(ir_in), .y_in_o(y_in), .zlow_in_o(zlow_in),
    .zhigh_in_o(zhigh_in), .hi_in_o(hi_in), .lo_in_o(lo_in), .inc_pc_o(inc_pc),
    .read_o(read), .operation_o(operation), .run_o(run), .illegal_o(illegal)
  );

  assign obs = {pc_out, mdr_out, zlow_out, zhigh_out, hi_out, lo_out, r_out, r_in,
                mar_in, pc_in, mdr_in, ir_in, y_in, zlow_in, zhigh_in, hi_in, lo_in,
                inc_pc, read, operation, run, illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction-set knowledge written from the opcode table
  function automatic bit is_exec(input logic [4:0] op);
    logic [4:0] ops [13] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10,
                             5'd11, 5'd14, 5'd15, 5'd16, 5'd17};
    foreach (ops[i]) if (ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit is_muldiv(input logic [4:0] op);
    return (op == 5'd14) || (op == 5'd15);
  endfunction

  function automatic bit is_unary(input logic [4:0] op);
    return (op == 5'd16) || (op == 5'd17);
  endfunction

  // Strobes expected in a given step of an instruction's micro-program
  function automatic out_t exp_of(input int ph, input logic [31:0] irv);
    out_t e;
    logic [4:0] op;
    int ra, rb, rc;
    e  = '0;
    op = irv[31:27];
    ra = int'(irv[26:23]);
    rb = int'(irv[22:19]);
    rc = int'(irv[18:15]);
    case (ph)
      P_F0: begin e.run = 1; e.pc_out = 1; e.mar_in = 1; e.inc_pc = 1; end
      P_F1: begin e.run = 1; e.read = 1; e.mdr_in = 1; end
      P_F2: begin e.run = 1; e.mdr_out = 1; e.ir_in = 1; end
      P_T3: begin
        e.run = 1;
        if (is_exec(op)) begin e.r_out = 16'(1 << rb); e.y_in = 1; end
        else if (op != 5'd26 && op != 5'd27) e.illegal = 1;
      end
      P_T4: begin
        e.run = 1; e.operation = op; e.zlow_in = 1; e.zhigh_in = 1;
        e.r_out = 16'(1 << (is_unary(op) ? rb : rc));
      end
      P_T5: begin
        e.run = 1; e.zlow_out = 1;
        if (is_muldiv(op)) e.lo_in = 1;
        else if (ra != 0) e.r_in = 16'(1 << ra);
      end
      P_T6: begin e.run = 1; e.zhigh_out = 1; e.hi_in = 1; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic check(input out_t exp, input string tag);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input out_t exp, input logic st, input logic mr, input string tag);
    stop = st;
    mem_ready = mr;
    @(negedge clk);
    check(exp, tag);
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction with w stall cycles in FETCH1. stop is random
  // mid-instruction (forced 1 from cycle stop_from if >= 0), stop_b at the
  // boundary cycle. clr_at >= 0 aborts the instruction with clr in that cycle.
  task automatic run_instr(input logic [31:0] irv, input int w, input int stop_from,
                           input logic stop_b, input int clr_at, input string tag);
    int         ph[$];
    logic [4:0] op;
    logic       st, mr;
    op = irv[31:27];
    ph.push_back(P_F0);
    for (int i = 0; i <= w; i++) ph.push_back(P_F1);
    ph.push_back(P_F2);
    ph.push_back(P_T3);
    if (is_exec(op)) begin
      ph.push_back(P_T4);
      ph.push_back(P_T5);
      if (is_muldiv(op)) ph.push_back(P_T6);
    end
    for (int k = 0; k < ph.size(); k++) begin
      ir = (k <= w + 2) ? $urandom : irv;
      if (k >= 1 && k <= w) mr = 1'b0;
      else if (k == w + 1)  mr = 1'b1;
      else                  mr = 1'($urandom);
      if (k == ph.size() - 1)             st = stop_b;
      else if (stop_from >= 0 && k >= stop_from) st = 1'b1;
      else                                st = 1'($urandom);
      if (k == clr_at) begin
        stop = st; mem_ready = mr;
        @(negedge clk);
        check(exp_of(ph[k], irv), $sformatf("%s c%0d", tag, k));
        clr = 1'b1;
        #1;
        check('0, {tag, " clr_async"});
        @(posedge clk);
        #1;
        check('0, {tag, " clr_hold"});
        clr = 1'b0;
        return;
      end
      step(exp_of(ph[k], irv), st, mr, $sformatf("%s c%0d", tag, k));
    end
  endtask

  // After a boundary with stop=1: n paused cycles, then release
  task automatic idle_then_go(input int n, input string tag);
    for (int i = 0; i < n; i++) step('0, 1'b1, 1'($urandom), {tag, " idle"});
    step('0, 1'b0, 1'($urandom), {tag, " idle_go"});
  endtask

  initial begin
    logic [31:0] irv;
    logic [4:0]  op;
    int          w;
    logic        sb;

    clr = 1'b1; stop = 1'b0; mem_ready = 1'b0; ir = '0;
    #1;
    check('0, "reset_async");
    @(posedge clk); #1;
    step('0, 1'b0, 1'b1, "reset_hold");
    clr = 1'b0;
    step('0, 1'b0, 1'b1, "post_reset_idle");

    run_instr(32'h1894_0000, 0, -1, 1'b0, -1, "add");
    irv = {5'b01110, 4'd6, 4'd3, 4'd5, 15'h0};
    run_instr(irv, 0, -1, 1'b0, -1, "mul");
    irv = {5'b01111, 4'd9, 4'd12, 4'd1, 15'h1234};
    run_instr(irv, 1, -1, 1'b0, -1, "div");
    run_instr(32'h1894_0000, 3, -1, 1'b0, -1, "add_stall3");
    irv = {5'b00011, 4'd0, 4'd5, 4'd6, 15'h0};
    run_instr(irv, 0, -1, 1'b0, -1, "add_r0");
    irv = {5'b10001, 4'd2, 4'd7, 4'd9, 15'h0};
    run_instr(irv, 0, -1, 1'b0, -1, "not");
    irv = {5'b10000, 4'd15, 4'd14, 4'd1, 15'h0};
    run_instr(irv, 0, -1, 1'b0, -1, "neg");
    irv = {5'b11111, 27'h5A5_A5A5};
    run_instr(irv, 0, -1, 1'b0, -1, "illegal");
    irv = {5'b11010, 27'h0};
    run_instr(irv, 2, -1, 1'b0, -1, "nop");

    // stop raised from T3 of an ADD: completes, then pauses
    run_instr(32'h1894_0000, 0, 3, 1'b1, -1, "add_stop");
    idle_then_go(3, "add_stop");

    // clr during T4 of an ADD
    run_instr(32'h1894_0000, 0, -1, 1'b0, 4, "add_clr_t4");
    step('0, 1'b0, 1'b1, "after_clr_idle");

    for (int n = 0; n < 40; n++) begin
      irv = $urandom;
      op  = 5'($urandom_range(0, 31));
      if (op == 5'd27) op = 5'd3;
      irv[31:27] = op;
      w  = $urandom_range(0, 3);
      sb = ($urandom_range(0, 3) == 0);
      run_instr(irv, w, -1, sb, -1, $sformatf("rnd%0d op%0d", n, op));
      if (sb) idle_then_go($urandom_range(0, 2), $sformatf("rnd%0d", n));
    end

    irv = {5'b11011, 27'h0};
    run_instr(irv, 0, -1, 1'b0, -1, "halt");
    for (int i = 0; i < 10; i++) step('0, 1'b0, 1'($urandom), $sformatf("halted%0d", i));
    clr = 1'b1;
    #1;
    check('0, "halt_clr");
    @(posedge clk); #1;
    clr = 1'b0;
    step('0, 1'b0, 1'b1, "halt_recover_idle");
    run_instr(32'h1894_0000, 0, -1, 1'b0, -1, "add_after_halt");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
